// File: rtl/cc_miss_scheduler_if.sv
// Miss-scheduler bundle: miss request side, AXI AR channel, and monitored R channel.
interface cc_miss_scheduler_if;
  logic        miss_valid_i;
  logic [31:0] miss_addr_i;
  logic        miss_ready_o;
  logic        merge_o;
  logic [3:0]  mem_arid_o;
  logic [31:0] mem_araddr_o;
  logic [3:0]  mem_arlen_o;
  logic [2:0]  mem_arsize_o;
  logic [1:0]  mem_arburst_o;
  logic        mem_arvalid_o;
  logic        mem_arready_i;
  logic [3:0]  mem_rid_i;
  logic        mem_rlast_i;
  logic        mem_rvalid_i;
  logic        mem_rready_i;
  logic        fill_done_o;
  logic [3:0]  fill_id_o;
  logic [31:0] fill_addr_o;
  logic [4:0]  outstanding_o;
  logic        err_o;

  // Scheduler side
  modport slave (
    input  miss_valid_i, miss_addr_i, mem_arready_i,
           mem_rid_i, mem_rlast_i, mem_rvalid_i, mem_rready_i,
    output miss_ready_o, merge_o, mem_arid_o, mem_araddr_o, mem_arlen_o,
           mem_arsize_o, mem_arburst_o, mem_arvalid_o,
           fill_done_o, fill_id_o, fill_addr_o, outstanding_o, err_o
  );

  // Cache / memory side
  modport master (
    output miss_valid_i, miss_addr_i, mem_arready_i,
           mem_rid_i, mem_rlast_i, mem_rvalid_i, mem_rready_i,
    input  miss_ready_o, merge_o, mem_arid_o, mem_araddr_o, mem_arlen_o,
           mem_arsize_o, mem_arburst_o, mem_arvalid_o,
           fill_done_o, fill_id_o, fill_addr_o, outstanding_o, err_o
  );
endinterface

// File: rtl/cc_miss_scheduler.sv
// Miss-request scheduler: merges repeat misses to in-flight lines, allocates a
// tracking entry (entry index = AXI ID) per new line, issues one WRAP burst per
// line and reports line-fill completion after the last R beat.
module cc_miss_scheduler #(
  parameter int MAX_OUTSTANDING = 4,
  parameter int BURST_BEATS     = 8
) (
  input logic             clk,
  input logic             rst,
  cc_miss_scheduler_if.slave bus
);

  localparam int             CNT_W     = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_BEATS - 1);
  localparam logic [4:0]     MAX_CNT   = 5'(MAX_OUTSTANDING);

  function automatic logic [4:0] count_valid(input logic [MAX_OUTSTANDING-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) n = n + 5'(v[i]);
    return n;
  endfunction

  // Tracking entries
  logic [MAX_OUTSTANDING-1:0] ent_vld;
  logic [25:0]                ent_line [MAX_OUTSTANDING];
  logic [CNT_W-1:0]           ent_cnt  [MAX_OUTSTANDING];

  // AR request register and registered outputs
  logic        ar_pending;
  logic [3:0]  ar_id_p1;
  logic [31:0] ar_addr_p1;
  logic        merge_p1;
  logic        fill_done_p1;
  logic [3:0]  fill_id_p1;
  logic [31:0] fill_addr_p1;
  logic        err_p1;

  logic [4:0]                 outstanding;
  logic                       miss_ready;
  logic                       accept;
  logic                       alloc;
  logic                       r_hs;
  logic                       bad_beat;
  logic [MAX_OUTSTANDING-1:0] beat_hit;
  logic [MAX_OUTSTANDING-1:0] retire;
  logic                       short_last;
  logic [25:0]                retire_line;
  logic                       match;
  logic [3:0]                 alloc_idx;
  logic                       free_found;
  logic                       addr_lsb_unused;

  assign outstanding     = count_valid(ent_vld);
  assign miss_ready      = !ar_pending && (outstanding < MAX_CNT);
  assign accept          = bus.miss_valid_i && miss_ready;
  assign r_hs            = bus.mem_rvalid_i && bus.mem_rready_i;
  assign bad_beat        = r_hs && !(|beat_hit);
  assign alloc           = accept && !match && free_found;
  assign addr_lsb_unused = ^bus.miss_addr_i[2:0];

  // Decode R beats, line match against surviving entries, lowest free entry
  always_comb begin
    beat_hit    = '0;
    retire      = '0;
    short_last  = 1'b0;
    retire_line = '0;
    match       = 1'b0;
    alloc_idx   = '0;
    free_found  = 1'b0;
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (r_hs && ent_vld[i] && (bus.mem_rid_i == 4'(i))) begin
        beat_hit[i] = 1'b1;
        if (bus.mem_rlast_i) begin
          retire[i]   = 1'b1;
          retire_line = ent_line[i];
          if (ent_cnt[i] != LAST_BEAT) short_last = 1'b1;
        end
      end
    end
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (ent_vld[i] && !retire[i] && (ent_line[i] == bus.miss_addr_i[31:6])) match = 1'b1;
    end
    // Free vector is taken before this cycle's retire, so a retiring entry is not eligible
    for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
      if (!ent_vld[i]) begin
        alloc_idx  = 4'(i);
        free_found = 1'b1;
      end
    end
  end

  // Entry valid bits: set on allocation, cleared on last beat or reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (rst)                                  ent_vld[i] <= 1'b0;
      else if (alloc && (alloc_idx == 4'(i)))   ent_vld[i] <= 1'b1;
      else if (retire[i])                       ent_vld[i] <= 1'b0;
    end
  end

  // Entry payload: line captured on allocation, beat counter advanced per non-last beat
  always_ff @(posedge clk) begin
    for (int i = 0; i < MAX_OUTSTANDING; i++) begin
      if (alloc && (alloc_idx == 4'(i))) begin
        ent_line[i] <= bus.miss_addr_i[31:6];
        ent_cnt[i]  <= '0;
      end else if (beat_hit[i] && !bus.mem_rlast_i) begin
        ent_cnt[i]  <= ent_cnt[i] + 1'b1;
      end
    end
  end

  // AR register: loaded on allocation, held stable until the handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      ar_pending <= 1'b0;
      ar_id_p1   <= '0;
      ar_addr_p1 <= '0;
    end else if (alloc) begin
      ar_pending <= 1'b1;
      ar_id_p1   <= alloc_idx;
      ar_addr_p1 <= {bus.miss_addr_i[31:3], 3'b000};
    end else if (ar_pending && bus.mem_arready_i) begin
      ar_pending <= 1'b0;
    end
  end

  // Stage 1: merge / fill-done pulses and the sticky protocol error
  always_ff @(posedge clk) begin
    if (rst) begin
      merge_p1     <= 1'b0;
      fill_done_p1 <= 1'b0;
      fill_id_p1   <= '0;
      fill_addr_p1 <= '0;
      err_p1       <= 1'b0;
    end else begin
      merge_p1     <= accept && match;
      fill_done_p1 <= |retire;
      if (|retire) begin
        fill_id_p1   <= bus.mem_rid_i;
        fill_addr_p1 <= {retire_line, 6'b0};
      end
      err_p1 <= err_p1 | bad_beat | short_last;
    end
  end

  assign bus.miss_ready_o  = miss_ready;
  assign bus.merge_o       = merge_p1;
  assign bus.mem_arid_o    = ar_id_p1;
  assign bus.mem_araddr_o  = ar_addr_p1;
  assign bus.mem_arlen_o   = 4'(BURST_BEATS - 1);
  assign bus.mem_arsize_o  = 3'b011;
  assign bus.mem_arburst_o = 2'b10;
  assign bus.mem_arvalid_o = ar_pending;
  assign bus.fill_done_o   = fill_done_p1;
  assign bus.fill_id_o     = fill_id_p1;
  assign bus.fill_addr_o   = fill_addr_p1;
  assign bus.outstanding_o = outstanding;
  assign bus.err_o         = err_p1;

endmodule

// File: doc/cc_miss_scheduler.md
# cc_miss_scheduler

Miss-request scheduler between the cache tag-compare stage and the memory AXI read-address channel. It accepts miss line addresses and merges repeat misses to a line that is already in flight. For each new line it allocates a tracking entry, whose index is the AXI ID, and issues one critical-word-first WRAP burst. It counts R beats per ID and signals line-fill completion to the data fill path.

## Interface
Parameters:
- MAX_OUTSTANDING, 4, number of tracking entries / distinct AXI IDs in flight (1..16)
- BURST_BEATS, 8, beats per line fill (64-bit beats, 64-byte line)

Ports:
- clk  input  1  sole clock, rising edge
- rst  input  1  synchronous, active-high reset
- miss_valid_i  input  1  miss request valid
- miss_addr_i  input  32  miss byte address {tag[16:0], index[8:0], offset[5:0]}
- miss_ready_o  output  1  scheduler can accept a miss this cycle
- merge_o  output  1  one-cycle pulse: accepted miss matched an in-flight line, no AR issued
- mem_arid_o  output  4  entry index of the issued request
- mem_araddr_o  output  32  {miss_addr_i[31:3], 3'b000}
- mem_arlen_o  output  4  constant BURST_BEATS-1 (4'd7)
- mem_arsize_o  output  3  constant 3'b011
- mem_arburst_o  output  2  constant 2'b10 (WRAP)
- mem_arvalid_o  output  1  AR request valid
- mem_arready_i  input  1  memory accepts AR
- mem_rid_i  input  4  R beat ID
- mem_rlast_i  input  1  R last beat
- mem_rvalid_i  input  1  R beat valid
- mem_rready_i  input  1  R ready as driven by the reorder unit; monitored only
- fill_done_o  output  1  one-cycle pulse: line fill complete
- fill_id_o  output  4  ID of completed fill
- fill_addr_o  output  32  line address of completed fill, {line[31:6], 6'b0}
- outstanding_o  output  5  number of valid entries
- err_o  output  1  sticky protocol error

## Operation
- Entry fields: valid, line[31:6], beat_cnt[2:0].
- miss_ready_o = !ar_pending && (outstanding_o < MAX_OUTSTANDING).
  - Depends on registered state only, never on miss_valid_i.
- Accept = miss_valid_i && miss_ready_o.
- On accept, compare miss_addr_i[31:6] against all valid entries not retiring this cycle.
  - Match: merge_o pulses next cycle. No allocation, no AR.
  - No match: allocate the lowest-index free entry. An entry freed in the same cycle is not eligible.
  - On allocation: line ← miss_addr_i[31:6], beat_cnt ← 0. Load the AR register with id = entry index and araddr = {miss_addr_i[31:3], 3'b0}. Set ar_pending.
- AR register: mem_arvalid_o = ar_pending.
  - id and addr stay stable while valid.
  - ar_pending clears on mem_arvalid_o && mem_arready_i.
- R tracking on beat handshake (mem_rvalid_i && mem_rready_i):
  - mem_rid_i ≥ MAX_OUTSTANDING or entry invalid: set err_o, ignore the beat.
  - Otherwise, without rlast: beat_cnt++.
  - Otherwise, with rlast:
    - If beat_cnt ≠ BURST_BEATS-1, set err_o. The entry is still freed.
    - Free the entry. Next cycle: fill_done_o=1, fill_id_o=rid, fill_addr_o={line, 6'b0}.
- Beats to an entry whose AR is still pending are legal. Counting starts from allocation.
- Simultaneous allocate and retire: outstanding_o net unchanged. Allocation uses the free vector from before the retire.
- err_o stays set until rst.

## Timing
- Reset: all entries invalid and ar_pending=0. Outputs after reset:
  - miss_ready_o=1 (combinational from cleared state)
  - merge_o, mem_arvalid_o, fill_done_o, err_o = 0
  - mem_arid_o, mem_araddr_o, fill_id_o, fill_addr_o, outstanding_o = 0
- Reset mid-burst drops all entries. Later R beats are flagged as errors unless memory is reset too.
- Accept at cycle T: mem_arvalid_o and outstanding_o updated at T+1. merge_o pulses at T+1.
- miss_ready_o is low from T+1 until the cycle after the AR handshake. Maximum new-miss rate: one per two cycles when arready is tied high. Merges have the same rate.
- rlast handshake at cycle T: fill_done_o pulses at T+1. outstanding_o decrements at T+1. The freed entry is allocatable from T+1.
- No combinational path from mem_* inputs to mem_arvalid_o or miss_ready_o.

## Test plan
- Single miss 0x1234_5678, arready=1 → at T+1: arvalid=1, arid=0, araddr=0x1234_5678, arlen=7, arsize=3, arburst=2. Then 8 beats ID0 with rlast on beat 8 → fill_done_o=1, fill_id_o=0, fill_addr_o=0x1234_5640.
- Miss 0x1000_0008, then 0x1000_0030 while ID0 is in flight → second accept gives merge_o=1 and no AR; outstanding_o stays 1.
- Four distinct-line misses with arready=1 → IDs 0,1,2,3 issued; outstanding_o=4; miss_ready_o=0. Fifth miss held until ID2 rlast, then allocated as ID2.
- arready held low for 5 cycles → arvalid, arid and araddr stable; miss_ready_o=0 throughout.
- ID1 burst whose rlast arrives on beat 4 → err_o=1 (sticky), entry freed, fill_done_o still pulses.
- Beat with rid=3 while entry 3 is invalid → err_o=1, no fill_done_o, outstanding_o unchanged. Then rst=1 for one cycle → err_o=0, outstanding_o=0.
